ping_pong_seg_display: RTL and testbench

- Downstream consumer of the ping-pong counter.
- Drives a 4-digit, common-anode 7-segment display with the counter's value (decimal 0..15) and its direction arrow.
- Time-multiplexes the digits and samples its inputs only at frame boundaries, so a displayed frame never tears.
- Sits between the counter outputs (out, direction) and the board's an/seg pins.

---
 rtl/ping_pong_seg_display_if.sv | 37 +++
 rtl/ping_pong_seg_display.sv | 110 +++++++++++
 tb/tb_ping_pong_seg_display.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ping_pong_seg_display_if.sv
// ping_pong_seg_display_if
//   Signal bundle between the ping-pong counter side and the 7-segment
//   display driver.
//   master : drives value/direction/blank, observes an/seg/frame_done
//   slave  : the display driver itself
//   value[3:0]  counter value to show (0..15)
//   direction   0 = counting up, 1 = counting down
//   blank       1 = all digits off, scanning continues
//   an[3:0]     digit enables, active-low, an[0] = rightmost digit
//   seg[6:0]    segments, active-low, {g,f,e,d,c,b,a}
//   frame_done  one-cycle pulse per completed 4-digit frame
interface ping_pong_seg_display_if;
    logic [3:0] value;
    logic       direction;
    logic       blank;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame_done;

    modport master (
        output value,
        output direction,
        output blank,
        input  an,
        input  seg,
        input  frame_done
    );

    modport slave (
        input  value,
        input  direction,
        input  blank,
        output an,
        output seg,
        output frame_done
    );
endinterface

// File: rtl/ping_pong_seg_display.sv
// ping_pong_seg_display
//   Time-multiplexed driver for a 4-digit common-anode 7-segment display.
//   Shows the ping-pong counter value (tens/ones on the two right digits)
//   and a direction arrow on the two left digits. Inputs are snapshotted
//   only when a frame wraps, so one frame never mixes two values.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  synchronous active-low reset
//     disp   slave side of ping_pong_seg_display_if
//            (value, direction, blank in; an, seg, frame_done out)
//   Parameters:
//     SCAN_PERIOD  clk cycles per digit (2..131071)
//     CNT_W        scan counter width, 2**CNT_W > SCAN_PERIOD
module ping_pong_seg_display #(
    parameter int SCAN_PERIOD = 100000,
    parameter int CNT_W       = 17
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ping_pong_seg_display_if.slave        disp
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_PERIOD - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;
    localparam logic [6:0] SEG_UP    = 7'b1011100;
    localparam logic [6:0] SEG_DOWN  = 7'b1100011;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [4:0]       snap, snap_nxt;       // {dir_s, val_s}
    logic [3:0]       an_q, an_nxt;
    logic [6:0]       seg_q, seg_nxt;
    logic             frame_done_q;
    logic             digit_last;
    logic             frame_wrap;
    logic [3:0]       val_nxt;
    logic             dir_nxt;
    logic             tens_nxt;
    logic [3:0]       ones_nxt;

    function automatic logic [6:0] decimal_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // Scan timing and frame snapshot
    always_comb begin
        digit_last = (cnt == CNT_LAST);
        frame_wrap = digit_last && (idx == 2'd3);
        cnt_nxt    = digit_last ? '0 : cnt + CNT_W'(1);
        idx_nxt    = digit_last ? idx + 2'd1 : idx;
        snap_nxt   = frame_wrap ? {disp.direction, disp.value} : snap;
    end

    // Outputs are decoded from the next idx/snap so that the first digit
    // of a new frame already shows the value captured on that same edge.
    always_comb begin
        dir_nxt  = snap_nxt[4];
        val_nxt  = snap_nxt[3:0];
        tens_nxt = (val_nxt >= 4'd10);
        ones_nxt = tens_nxt ? (val_nxt - 4'd10) : val_nxt;

        case (idx_nxt)
            2'd0:    seg_nxt = decimal_glyph(ones_nxt);
            2'd1:    seg_nxt = tens_nxt ? SEG_ONE : SEG_BLANK;
            default: seg_nxt = dir_nxt ? SEG_DOWN : SEG_UP;
        endcase

        an_nxt = disp.blank ? 4'b1111 : ~(4'b0001 << idx_nxt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= '0;
            idx          <= 2'd0;
            snap         <= 5'd0;
            an_q         <= 4'b1110;
            seg_q        <= SEG_ZERO;
            frame_done_q <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            idx          <= idx_nxt;
            snap         <= snap_nxt;
            an_q         <= an_nxt;
            seg_q        <= seg_nxt;
            frame_done_q <= frame_wrap;
        end
    end

    assign disp.an         = an_q;
    assign disp.seg        = seg_q;
    assign disp.frame_done = frame_done_q;

endmodule

// File: tb/tb_ping_pong_seg_display.sv
// tb_ping_pong_seg_display
//   Self-checking bench for ping_pong_seg_display with SCAN_PERIOD = 4.
//   A table of {value, direction, expected per-digit segments} records is
//   applied frame by frame, followed by hand-written sequences for reset
//   timing, mid-frame input changes, blanking and reset during a frame.
module tb_ping_pong_seg_display;

    localparam int SP = 4;

    localparam logic [6:0] G0  = 7'b1000000;
    localparam logic [6:0] G1  = 7'b1111001;
    localparam logic [6:0] G2  = 7'b0100100;
    localparam logic [6:0] G3  = 7'b0110000;
    localparam logic [6:0] G4  = 7'b0011001;
    localparam logic [6:0] G5  = 7'b0010010;
    localparam logic [6:0] G6  = 7'b0000010;
    localparam logic [6:0] G7  = 7'b1111000;
    localparam logic [6:0] G8  = 7'b0000000;
    localparam logic [6:0] G9  = 7'b0010000;
    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [6:0] UP  = 7'b1011100;
    localparam logic [6:0] DN  = 7'b1100011;

    typedef struct packed {
        logic [3:0]      value;
        logic            dir;
        logic [3:0][6:0] exp_seg;   // [3]=idx3 ... [0]=idx0
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    vec_t vecs [11];

    ping_pong_seg_display_if disp_if ();

    ping_pong_seg_display #(
        .SCAN_PERIOD (SP),
        .CNT_W       (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .disp  (disp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance until the cycle right after a frame boundary edge.
    task automatic wait_boundary(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8 * SP && !seen; i++) begin
            step(1);
            if (disp_if.frame_done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL %s: frame_done not seen within %0d cycles", name, 8 * SP);
        end
    endtask

    initial begin
        vecs[0]  = '{4'd13, 1'b0, {UP, UP, G1,  G3}};
        vecs[1]  = '{4'd7,  1'b1, {DN, DN, BLK, G7}};
        vecs[2]  = '{4'd9,  1'b0, {UP, UP, BLK, G9}};
        vecs[3]  = '{4'd10, 1'b1, {DN, DN, G1,  G0}};
        vecs[4]  = '{4'd15, 1'b0, {UP, UP, G1,  G5}};
        vecs[5]  = '{4'd0,  1'b1, {DN, DN, BLK, G0}};
        vecs[6]  = '{4'd12, 1'b1, {DN, DN, G1,  G2}};
        vecs[7]  = '{4'd6,  1'b0, {UP, UP, BLK, G6}};
        vecs[8]  = '{4'd8,  1'b1, {DN, DN, BLK, G8}};
        vecs[9]  = '{4'd4,  1'b0, {UP, UP, BLK, G4}};
        vecs[10] = '{4'd11, 1'b1, {DN, DN, G1,  G1}};

        n_checks = 0;
        n_errors = 0;
        rst_n             = 1'b0;
        disp_if.value     = 4'd0;
        disp_if.direction = 1'b0;
        disp_if.blank     = 1'b0;

        // Reset state and scan timing from reset
        step(2);
        chk("reset_an",  {4'b0, disp_if.an},  {4'b0, 4'b1110});
        chk("reset_seg", {1'b0, disp_if.seg}, {1'b0, G0});
        chk("reset_fd",  {7'b0, disp_if.frame_done}, 8'd0);
        rst_n = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            logic [3:0] exp_an;
            step(1);
            if (c < 4)       exp_an = 4'b1110;
            else if (c < 8)  exp_an = 4'b1101;
            else if (c < 12) exp_an = 4'b1011;
            else if (c < 16) exp_an = 4'b0111;
            else             exp_an = 4'b1110;
            chk($sformatf("scan_an_c%0d", c), {4'b0, disp_if.an}, {4'b0, exp_an});
            chk($sformatf("scan_fd_c%0d", c), {7'b0, disp_if.frame_done}, {7'b0, (c == 16)});
            if (c == 4)  chk("scan_seg_tens_blank", {1'b0, disp_if.seg}, {1'b0, BLK});
            if (c == 8)  chk("scan_seg_arrow_up",   {1'b0, disp_if.seg}, {1'b0, UP});
            if (c == 16) chk("scan_seg_zero",       {1'b0, disp_if.seg}, {1'b0, G0});
        end

        // Table-driven frames: inputs are applied during idx3, picked up at
        // the next boundary, then every digit of that frame is checked.
        for (int v = 0; v < 11; v++) begin
            disp_if.value     = vecs[v].value;
            disp_if.direction = vecs[v].dir;
            wait_boundary($sformatf("vec%0d_boundary", v));
            for (int d = 0; d < 4; d++) begin
                logic [3:0] exp_an;
                if (d > 0) step(SP);
                exp_an = 4'b1111;
                exp_an[d] = 1'b0;
                chk($sformatf("vec%0d_v%0d_an%0d", v, vecs[v].value, d),
                    {4'b0, disp_if.an}, {4'b0, exp_an});
                chk($sformatf("vec%0d_v%0d_seg%0d", v, vecs[v].value, d),
                    {1'b0, disp_if.seg}, {1'b0, vecs[v].exp_seg[d]});
            end
        end

        // Mid-frame input change stays invisible until the next boundary
        disp_if.value     = 4'd13;
        disp_if.direction = 1'b0;
        wait_boundary("mid_load_boundary");
        step(9);
        disp_if.value     = 4'd14;
        disp_if.direction = 1'b1;
        step(3);
        chk("mid_idx3_an",  {4'b0, disp_if.an},  {4'b0, 4'b0111});
        chk("mid_idx3_seg", {1'b0, disp_if.seg}, {1'b0, UP});
        wait_boundary("mid_next_boundary");
        chk("mid_new_idx0", {1'b0, disp_if.seg}, {1'b0, G4});
        step(SP);
        chk("mid_new_idx1", {1'b0, disp_if.seg}, {1'b0, G1});
        step(SP);
        chk("mid_new_idx2", {1'b0, disp_if.seg}, {1'b0, DN});

        // Blank for 10 cycles mid-frame
        disp_if.value     = 4'd7;
        disp_if.direction = 1'b1;
        wait_boundary("blank_boundary");
        for (int c = 1; c <= 16; c++) begin
            logic [3:0] exp_an;
            step(1);
            exp_an = 4'b1111;
            if (c < 3 || c > 12) exp_an[(c / 4) % 4] = 1'b0;
            chk($sformatf("blank_an_c%0d", c), {4'b0, disp_if.an}, {4'b0, exp_an});
            chk($sformatf("blank_fd_c%0d", c), {7'b0, disp_if.frame_done}, {7'b0, (c == 16)});
            if (c == 2)  disp_if.blank = 1'b1;
            if (c == 12) disp_if.blank = 1'b0;
        end
        chk("blank_after_seg", {1'b0, disp_if.seg}, {1'b0, G7});

        // Reset for one cycle during idx3
        disp_if.value     = 4'd13;
        disp_if.direction = 1'b1;
        wait_boundary("rst_boundary");
        step(13);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("rst_mid_an",  {4'b0, disp_if.an},  {4'b0, 4'b1110});
        chk("rst_mid_seg", {1'b0, disp_if.seg}, {1'b0, G0});
        chk("rst_mid_fd",  {7'b0, disp_if.frame_done}, 8'd0);
        for (int c = 1; c <= 16; c++) begin
            step(1);
            chk($sformatf("rst_fd_c%0d", c), {7'b0, disp_if.frame_done}, {7'b0, (c == 16)});
            if (c == 4)  chk("rst_snap_tens", {1'b0, disp_if.seg}, {1'b0, BLK});
            if (c == 8)  chk("rst_snap_dir",  {1'b0, disp_if.seg}, {1'b0, UP});
            if (c == 16) chk("rst_reload",    {1'b0, disp_if.seg}, {1'b0, G3});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
